gpr_wr_arb: RTL and testbench

GPR_WR_ARB -- requirements
Module: gpr_wr_arb

---
 rtl/gpr_wr_arb.sv | 118 +++++++++++
 tb/tb_gpr_wr_arb.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpr_wr_arb.sv
// Three-requester GPR write-port arbiter with a registered, active-low write strobe.
// Define GPR_ARB_RR_EN for round-robin priority; otherwise priority is fixed 0 > 1 > 2.
module gpr_wr_arb #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic              req_0,
    input  logic              req_1,
    input  logic              req_2,
    input  logic [ADDR_W-1:0] addr_0,
    input  logic [ADDR_W-1:0] addr_1,
    input  logic [ADDR_W-1:0] addr_2,
    input  logic [DATA_W-1:0] data_0,
    input  logic [DATA_W-1:0] data_1,
    input  logic [DATA_W-1:0] data_2,
    output logic              gnt_0,
    output logic              gnt_1,
    output logic              gnt_2,
    output logic              we_,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic [1:0]        dbg_last_gnt
);

    // Handshake: a requester keeps req_n/addr_n/data_n stable until it sees
    // gnt_n high; the write then appears on we_/wr_addr/wr_data one edge later.

    logic [2:0]        w_req_raw;
    logic [2:0]        w_req;
    logic [2:0]        w_gnt;
    logic              w_any_gnt;
    logic [1:0]        w_gnt_idx;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;

    logic              r_we_n;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic [1:0]        r_last_gnt;

    assign w_req_raw = {req_2, req_1, req_0};
    // Reset also masks grants so nothing is offered while the block is held in reset.
    assign w_req     = w_req_raw & {3{~hold & ~reset}};

    always_comb begin
        w_gnt = 3'b000;
`ifdef GPR_ARB_RR_EN
        case (r_last_gnt)
            2'd0: begin
                if (w_req[1])      w_gnt = 3'b010;
                else if (w_req[2]) w_gnt = 3'b100;
                else if (w_req[0]) w_gnt = 3'b001;
            end
            2'd1: begin
                if (w_req[2])      w_gnt = 3'b100;
                else if (w_req[0]) w_gnt = 3'b001;
                else if (w_req[1]) w_gnt = 3'b010;
            end
            default: begin
                if (w_req[0])      w_gnt = 3'b001;
                else if (w_req[1]) w_gnt = 3'b010;
                else if (w_req[2]) w_gnt = 3'b100;
            end
        endcase
`else
        if (w_req[0])      w_gnt = 3'b001;
        else if (w_req[1]) w_gnt = 3'b010;
        else if (w_req[2]) w_gnt = 3'b100;
`endif
    end

    assign w_any_gnt = |w_gnt;

    always_comb begin
        w_gnt_idx  = 2'd0;
        w_sel_addr = addr_0;
        w_sel_data = data_0;
        if (w_gnt[1]) begin
            w_gnt_idx  = 2'd1;
            w_sel_addr = addr_1;
            w_sel_data = data_1;
        end else if (w_gnt[2]) begin
            w_gnt_idx  = 2'd2;
            w_sel_addr = addr_2;
            w_sel_data = data_2;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we_n     <= 1'b1;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_last_gnt <= 2'd2;
        end else if (w_any_gnt) begin
            r_we_n     <= 1'b0;
            r_wr_addr  <= w_sel_addr;
            r_wr_data  <= w_sel_data;
            r_last_gnt <= w_gnt_idx;
        end else begin
            r_we_n     <= 1'b1;
        end
    end

    assign gnt_0        = w_gnt[0];
    assign gnt_1        = w_gnt[1];
    assign gnt_2        = w_gnt[2];
    assign we_          = r_we_n;
    assign wr_addr      = r_wr_addr;
    assign wr_data      = r_wr_data;
    assign busy         = (|w_req_raw) & ~w_any_gnt & ~reset;
    assign dbg_last_gnt = r_last_gnt;

endmodule

// File: tb/tb_gpr_wr_arb.sv
// Self-checking bench for gpr_wr_arb: directed scenarios plus randomized traffic
// compared every cycle against a queue-free behavioural arbitration model.
module tb_gpr_wr_arb;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  logic clk;
  logic reset;
  logic hold;
  logic [2:0] req;
  logic [ADDR_W-1:0] addr [3];
  logic [DATA_W-1:0] data [3];
  logic gnt_0, gnt_1, gnt_2, we_, busy;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [1:0] dbg_last_gnt;

  int n_checks = 0;
  int n_errors = 0;

  gpr_wr_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .hold(hold),
    .req_0(req[0]), .req_1(req[1]), .req_2(req[2]),
    .addr_0(addr[0]), .addr_1(addr[1]), .addr_2(addr[2]),
    .data_0(data[0]), .data_1(data[1]), .data_2(data[2]),
    .gnt_0(gnt_0), .gnt_1(gnt_1), .gnt_2(gnt_2),
    .we_(we_), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .dbg_last_gnt(dbg_last_gnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic              m_we_n;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  int                m_ptr;
  int                wait_cnt [3];

  // Winner among requests: scan from the slot after the last grant (RR) or from 0.
  function automatic int m_grant(input logic [2:0] r, input logic h, input int ptr);
    if (h) return -1;
`ifdef GPR_ARB_RR_EN
    for (int k = 1; k <= 3; k++) begin
      int c;
      c = (ptr + k) % 3;
      if (r[c]) return c;
    end
`else
    for (int c = 0; c < 3; c++)
      if (r[c]) return c;
`endif
    return -1;
  endfunction

  always @(posedge clk or posedge reset) begin
    int g;
    if (reset) begin
      m_we_n <= 1'b1;
      m_addr <= '0;
      m_data <= '0;
      m_ptr  <= 2;
    end else begin
      g = m_grant(req, hold, m_ptr);
      if (g >= 0) begin
        m_we_n <= 1'b0;
        m_addr <= addr[g];
        m_data <= data[g];
        m_ptr  <= g;
      end else begin
        m_we_n <= 1'b1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int g;
    logic [2:0] eg;
    logic eb;
    g  = reset ? -1 : m_grant(req, hold, m_ptr);
    eg = (g >= 0) ? (3'b001 << g) : 3'b000;
    eb = !reset && (|req) && (g < 0);
    chk("gnt", {gnt_2, gnt_1, gnt_0}, eg);
    chk("busy", busy, eb);
    chk("we_", we_, m_we_n);
    chk("wr_addr", wr_addr, m_addr);
    chk("wr_data", wr_data, m_data);
    chk("last_gnt", dbg_last_gnt, m_ptr[1:0]);
    for (int n = 0; n < 3; n++) begin
      if (reset || !req[n]) wait_cnt[n] = 0;
      else if (g == n) begin
`ifdef GPR_ARB_RR_EN
        chk("rr_latency", wait_cnt[n] <= 2, 1'b1);
`endif
        wait_cnt[n] = 0;
      end else if (!hold) wait_cnt[n]++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req  = 3'b000;
    hold = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic set_req(input int n, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req[n]  = 1'b1;
    addr[n] = a;
    data[n] = d;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int exp_seq [6];
    int g;
    reset = 1'b0;
    hold  = 1'b0;
    req   = 3'b000;
    for (int n = 0; n < 3; n++) begin
      addr[n] = '0;
      data[n] = '0;
      wait_cnt[n] = 0;
    end
    #1 reset = 1'b1;
    req = 3'b111;

    // Reset state, with requests present to show grants/busy are masked.
    @(negedge clk);
    chk("rst_we_", we_, 1'b1);
    chk("rst_addr", wr_addr, 0);
    chk("rst_data", wr_data, 0);
    chk("rst_gnt", {gnt_2, gnt_1, gnt_0}, 3'b000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ptr", dbg_last_gnt, 2'd2);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle();

    // Single write from requester 1.
    set_req(1, 5'd5, 32'h1234);
    @(negedge clk);
    chk("single_gnt", {gnt_2, gnt_1, gnt_0}, 3'b010);
    tick();
    idle();
    @(negedge clk);
    chk("single_we_", we_, 1'b0);
    chk("single_addr", wr_addr, 5'd5);
    chk("single_data", wr_data, 32'h1234);
    tick();
    @(negedge clk);
    chk("single_we_off", we_, 1'b1);
    chk("single_addr_keep", wr_addr, 5'd5);

    // All requesters held high for six cycles.
`ifdef GPR_ARB_RR_EN
    exp_seq = '{0, 1, 2, 0, 1, 2};
`else
    exp_seq = '{0, 0, 0, 0, 0, 0};
`endif
    do_reset();
    set_req(0, 5'd1, 32'h10);
    set_req(1, 5'd2, 32'h20);
    set_req(2, 5'd3, 32'h30);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("all3_order", {gnt_2, gnt_1, gnt_0}, 3'b001 << exp_seq[i]);
      if (i > 0) chk("all3_we_", we_, 1'b0);
      tick();
    end
    @(negedge clk);
    chk("all3_we_last", we_, 1'b0);
    tick();

    // Requesters 0 and 2 only.
    do_reset();
    set_req(0, 5'd4, 32'h44);
    set_req(2, 5'd6, 32'h66);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
`ifdef GPR_ARB_RR_EN
      chk("r02_gnt", {gnt_2, gnt_1, gnt_0}, (i % 2 == 0) ? 3'b001 : 3'b100);
`else
      chk("r02_gnt", {gnt_2, gnt_1, gnt_0}, 3'b001);
`endif
      tick();
    end

    // Hold after a grant: the registered write still lands, new grants wait.
    do_reset();
    set_req(0, 5'd3, 32'hA);
    @(negedge clk);
    chk("hold_gnt0", {gnt_2, gnt_1, gnt_0}, 3'b001);
    tick();
    req[0] = 1'b0;
    hold   = 1'b1;
    set_req(1, 5'd9, 32'h55);
    @(negedge clk);
    chk("hold_we_", we_, 1'b0);
    chk("hold_addr", wr_addr, 5'd3);
    chk("hold_data", wr_data, 32'hA);
    chk("hold_gnt", {gnt_2, gnt_1, gnt_0}, 3'b000);
    chk("hold_busy", busy, 1'b1);
    tick();
    @(negedge clk);
    chk("hold2_we_", we_, 1'b1);
    chk("hold2_busy", busy, 1'b1);
    tick();
    hold = 1'b0;
    @(negedge clk);
    chk("unhold_gnt1", {gnt_2, gnt_1, gnt_0}, 3'b010);
    tick();
    idle();

    // Same address from two requesters is written twice, in order.
    do_reset();
    set_req(0, 5'd7, 32'h1);
    set_req(1, 5'd7, 32'h2);
    @(negedge clk);
    chk("same_gnt0", {gnt_2, gnt_1, gnt_0}, 3'b001);
    tick();
    req[0] = 1'b0;
    @(negedge clk);
    chk("same_gnt1", {gnt_2, gnt_1, gnt_0}, 3'b010);
    chk("same_w1_addr", wr_addr, 5'd7);
    chk("same_w1_data", wr_data, 32'h1);
    tick();
    idle();
    @(negedge clk);
    chk("same_w2_we_", we_, 1'b0);
    chk("same_w2_addr", wr_addr, 5'd7);
    chk("same_w2_data", wr_data, 32'h2);
    tick();

    // Reset in the cycle after a grant discards the registered write.
    do_reset();
    set_req(1, 5'd12, 32'hBEEF);
    tick();
    chk("mid_we_before", we_, 1'b0);
    req = 3'b111;
    #2 reset = 1'b1;
    #1;
    chk("mid_we_async", we_, 1'b1);
    chk("mid_addr_async", wr_addr, 0);
    chk("mid_data_async", wr_data, 0);
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_gnt0", {gnt_2, gnt_1, gnt_0}, 3'b001);
    tick();
    idle();

    // Randomized traffic obeying the hold-until-granted handshake.
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      g = m_grant(req, hold, m_ptr);
      tick();
      for (int n = 0; n < 3; n++) begin
        if (!req[n] || g == n) begin
          if ($urandom_range(0, 99) < 60)
            set_req(n, ADDR_W'($urandom_range(0, 31)), $urandom);
          else
            req[n] = 1'b0;
        end
      end
      hold = ($urandom_range(0, 4) == 0);
    end
    idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
